// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, mid-bit tick helper, counter width helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } rx_state_e;

  // Centre tick of a bit period for a given oversampling ratio.
  function automatic int unsigned mid_of(input int unsigned oversample);
    return oversample / 2;
  endfunction

  localparam int unsigned OVERSAMPLE_DFLT = 16;
  localparam int unsigned MID             = mid_of(OVERSAMPLE_DFLT);

  // Width of a counter that must hold 0..n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous idle-high line; both flops reset to 1.
//   clk : sampling clock
//   rst : asynchronous active-low reset
//   d   : asynchronous input
//   q   : synchronised output
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default, LSB first, 3-sample majority vote around mid-bit.
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   en_rx     : one-cycle tick at OVERSAMPLE x baud
//   rxd       : asynchronous serial line, idle high
//   rx_data   : received byte, stable while rx_valid
//   rx_valid  : holding register full
//   rx_ready  : consumer accepts rx_data when rx_valid & rx_ready
//   frame_err : one-cycle pulse, stop bit voted low
//   overrun   : one-cycle pulse, byte completed while holding register full
//   busy      : receiver not idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_rx,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned TW       = cnt_width(OVERSAMPLE);
  localparam int unsigned BW       = cnt_width(DATA_BITS);
  localparam int unsigned MID_TICK = mid_of(OVERSAMPLE);

  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_LO   = TW'(MID_TICK - 1);
  localparam logic [TW-1:0] T_MID  = TW'(MID_TICK);
  localparam logic [TW-1:0] T_HI   = TW'(MID_TICK + 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [1:0]           win_q, win_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_d;
  logic                 valid_d, ferr_d, ovr_d, busy_d;
  logic                 rxs, vote;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxs)
  );

  // The window holds the samples from MID-1 and MID; the third sample is rxs itself at MID+1.
  assign vote = (win_q[1] & win_q[0]) | (win_q[1] & rxs) | (win_q[0] & rxs);

  // Next-state, counters, vote window, shift register and holding register.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    win_d   = win_q;
    shreg_d = shreg_q;
    data_d  = rx_data;
    valid_d = rx_valid & ~rx_ready;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    if (en_rx) begin
      case (state_q)
        IDLE: begin
          if (!rxs) begin
            state_d = START;
            tick_d  = TW'(1);
          end
        end
        BRK: begin
          if (rxs) begin
            state_d = IDLE;
            tick_d  = '0;
          end
        end
        default: begin
          tick_d = (tick_q == T_LAST) ? '0 : tick_q + TW'(1);
          if (tick_q == T_LO || tick_q == T_MID) begin
            win_d = {win_q[0], rxs};
          end
          if (tick_q == T_HI) begin
            case (state_q)
              START: begin
                if (vote) begin
                  state_d = IDLE;
                  tick_d  = '0;
                end else begin
                  state_d = DATA;
                  bit_d   = '0;
                end
              end
              DATA: begin
                shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
                bit_d   = bit_q + BW'(1);
                if (bit_q == B_LAST) begin
                  state_d = STOP;
                end
              end
              STOP: begin
                tick_d = '0;
                if (vote) begin
                  state_d = IDLE;
                  // A byte consumed in this same cycle frees the register for the new one.
                  if (!rx_valid || rx_ready) begin
                    data_d  = shreg_q;
                    valid_d = 1'b1;
                  end else begin
                    ovr_d = 1'b1;
                  end
                end else begin
                  state_d = BRK;
                  ferr_d  = 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      win_q     <= '0;
      shreg_q   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      win_q     <= win_d;
      shreg_q   <= shreg_d;
      rx_data   <= data_d;
      rx_valid  <= valid_d;
      frame_err <= ferr_d;
      overrun   <= ovr_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame-level scoreboard plus literal spot checks.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int unsigned OS     = 16;
  localparam int unsigned DB     = 8;
  localparam int unsigned EN_DIV = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en_rx = 1'b0;
  logic          rxd = 1'b1;
  logic          rx_ready = 1'b0;
  logic [DB-1:0] rx_data;
  logic          rx_valid, frame_err, overrun, busy;

  int total = 0;
  int bad   = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;

  // Model: expected frame-level events (kind*256 + data) and holding-register occupancy.
  localparam int EV_LOAD = 1;
  localparam int EV_FERR = 2;
  localparam int EV_OVR  = 3;
  int exp_q[$];
  bit mv = 1'b0;

  uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .en_rx     (en_rx),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // en_rx once every EN_DIV clocks, changed on the falling edge.
  initial begin
    int div = 0;
    forever begin
      @(negedge clk);
      en_rx = (div == 0);
      div = (div + 1) % EN_DIV;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pop_expect(input int kind, input logic [7:0] d, input string name);
    int e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got event 0x%0h expected no event", name, kind * 256 + int'(d));
    end else begin
      e = exp_q.pop_front();
      check(name, 32'(kind * 256 + int'(d)), 32'(e));
    end
  endtask

  // Compare process: every observed event must match the head of the model queue.
  initial begin
    logic          pv;
    logic [DB-1:0] pd;
    pv = 1'b0;
    pd = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pv = 1'b0;
        pd = '0;
      end else begin
        if (frame_err || overrun) check("err_exclusive", 32'(frame_err & overrun), 32'd0);
        if (frame_err) begin
          ferr_cnt++;
          pop_expect(EV_FERR, 8'h00, "frame_err");
        end
        if (overrun) begin
          ovr_cnt++;
          pop_expect(EV_OVR, 8'h00, "overrun");
        end
        if (rx_valid && (!pv || rx_data != pd)) pop_expect(EV_LOAD, rx_data, "load");
        pv = rx_valid;
        pd = rx_data;
      end
    end
  end

  // Model of the holding register at byte completion.
  task automatic expect_byte(input logic [7:0] b, input bit ready_at_c);
    if (!mv || ready_at_c) begin
      exp_q.push_back(EV_LOAD * 256 + int'(b));
      mv = 1'b1;
    end else begin
      exp_q.push_back(EV_OVR * 256);
    end
  endtask

  // Advance n en_rx ticks; returns just after the n-th tick edge.
  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (en_rx !== 1'b1);
    end
    #1;
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    mv = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // One frame: start, data LSB first, stop. glitch inverts the mid-bit sample of each data bit;
  // rdy_pulse raises rx_ready only in the cycle of the stop-bit vote.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit glitch,
                            input bit rdy_pulse);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      if (glitch && i >= 1 && i <= 8) begin
        wait_ticks(8);
        rxd = ~bits[i];
        wait_ticks(1);
        rxd = bits[i];
        wait_ticks(7);
      end else if (rdy_pulse && i == 9) begin
        wait_ticks(9);
        repeat (8) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
        wait_ticks(6);
      end else begin
        wait_ticks(16);
      end
    end
  endtask

  initial begin
    int  lat;
    bit  saw_busy;
    bit  stayed_busy;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_data", 32'(rx_data), 32'h0);
    check("rst_rx_valid", 32'(rx_valid), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    wait_ticks(4);

    // 0xA5, held with rx_ready low; latency from start edge = 154 ticks * 9 clk
    expect_byte(8'hA5, 1'b0);
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
      begin
        do begin
          @(posedge clk);
          lat++;
          #1;
        end while (!rx_valid && lat < 3000);
      end
    join
    check("a5_latency", 32'(lat), 32'd1386);
    check("a5_data", 32'(rx_data), 32'hA5);
    check("a5_valid", 32'(rx_valid), 32'h1);
    drain("a5_drain");
    repeat (50) @(posedge clk);
    #1;
    check("a5_held_data", 32'(rx_data), 32'hA5);
    check("a5_held_valid", 32'(rx_valid), 32'h1);
    check("a5_no_ferr", 32'(ferr_cnt), 32'd0);
    consume();
    check("a5_cleared", 32'(rx_valid), 32'h0);

    // Short start pulse: glitch rejected
    saw_busy = 1'b0;
    rxd = 1'b0;
    repeat (4) begin
      wait_ticks(1);
      saw_busy |= busy;
    end
    rxd = 1'b1;
    repeat (20) begin
      wait_ticks(1);
      saw_busy |= busy;
    end
    check("glitch_busy_seen", 32'(saw_busy), 32'h1);
    check("glitch_busy_low", 32'(busy), 32'h0);
    check("glitch_no_valid", 32'(rx_valid), 32'h0);
    check("glitch_no_ferr", 32'(ferr_cnt), 32'd0);

    // 0x3C with stop low, line held low one more bit time
    exp_q.push_back(EV_FERR * 256);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    stayed_busy = 1'b1;
    repeat (16) begin
      wait_ticks(1);
      if (!busy) stayed_busy = 1'b0;
    end
    drain("ferr_drain");
    check("ferr_count", 32'(ferr_cnt), 32'd1);
    check("ferr_no_valid", 32'(rx_valid), 32'h0);
    check("ferr_no_restart", 32'(stayed_busy), 32'h1);
    rxd = 1'b1;
    wait_ticks(4);
    check("ferr_idle_after_high", 32'(busy), 32'h0);
    wait_ticks(16);

    // 0x11 then 0x22 back-to-back, rx_ready low: overrun
    expect_byte(8'h11, 1'b0);
    expect_byte(8'h22, 1'b0);
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    drain("ovr_drain");
    check("ovr_data", 32'(rx_data), 32'h11);
    check("ovr_valid", 32'(rx_valid), 32'h1);
    check("ovr_count", 32'(ovr_cnt), 32'd1);
    consume();
    wait_ticks(16);

    // Same pair, rx_ready pulsed in the second completion cycle
    expect_byte(8'h11, 1'b0);
    expect_byte(8'h22, 1'b1);
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b1);
    drain("swap_drain");
    check("swap_data", 32'(rx_data), 32'h22);
    check("swap_valid", 32'(rx_valid), 32'h1);
    check("swap_ovr_count", 32'(ovr_cnt), 32'd1);
    consume();
    wait_ticks(16);

    // 0x5A with one inverted sample per data bit
    expect_byte(8'h5A, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    drain("vote_drain");
    check("vote_data", 32'(rx_data), 32'h5A);
    consume();
    wait_ticks(16);

    // Reset during data bit 4 of 0xFF, then 0x81
    rxd = 1'b0;
    wait_ticks(16);
    rxd = 1'b1;
    wait_ticks(16 * 4 + 8);
    check("rst_mid_busy", 32'(busy), 32'h1);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_busy_clr", 32'(busy), 32'h0);
    check("rst_mid_valid_clr", 32'(rx_valid), 32'h0);
    exp_q.delete();
    mv = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    wait_ticks(8 + 16 * 4);
    check("rst_mid_no_restart", 32'(busy), 32'h0);
    expect_byte(8'h81, 1'b0);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    drain("rst_drain");
    check("rst_81_data", 32'(rx_data), 32'h81);
    check("rst_81_valid", 32'(rx_valid), 32'h1);
    check("rst_no_new_ferr", 32'(ferr_cnt), 32'd1);
    check("rst_no_new_ovr", 32'(ovr_cnt), 32'd1);
    consume();

    wait_ticks(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
